cmos_pixel_packer: RTL and testbench

Parametrised camera byte-bus to pixel-word packer for the OV5640 capture path. It samples the 8-bit DVP bus and assembles BPP bytes per pixel: RAW8 (1), RGB565/YUV422 (2) or RGB888 (3). It attaches pixel coordinates, applies a runtime crop window and flags malformed lines. It sits between the sensor pins and the frame-buffer write FIFO, and replaces the fixed 16-bit converter.

---
 rtl/cmos_pkg.sv | 10 +
 rtl/cmos_pixel_packer_if.sv | 14 +
 rtl/cmos_sync_edge.sv | 21 ++
 rtl/cmos_pixel_packer.sv | 113 +++++++++++
 tb/tb_cmos_pixel_packer.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cmos_pkg.sv
// cmos_pkg: shared bytes-per-pixel constants and FSM state encoding for the DVP pixel packer
package cmos_pkg;
   localparam int BPP_MIN    = 1;
   localparam int BPP_MAX    = 4;
   localparam int BPP_RAW8   = 1;
   localparam int BPP_RGB565 = 2;
   localparam int BPP_YUV422 = 2;
   localparam int BPP_RGB888 = 3;
   typedef enum logic [1:0] {S_WAIT_FRAME, S_HBLANK, S_ACTIVE} state_t;
endpackage

// File: rtl/cmos_pixel_packer_if.sv
// cmos_pixel_packer_if: pixel word bus from the packer towards the frame-buffer write FIFO
interface cmos_pixel_packer_if import cmos_pkg::*; #(
   parameter int BPP     = BPP_RGB565,
   parameter int COORD_W = 12
);
   logic               pix_vld_o;
   logic [8*BPP-1:0]   pix_data_o;
   logic [COORD_W-1:0] pix_x_o;
   logic [COORD_W-1:0] pix_y_o;
   logic               sof_o;
   logic               eol_o;
   modport master (output pix_vld_o, pix_data_o, pix_x_o, pix_y_o, sof_o, eol_o);
   modport slave  (input  pix_vld_o, pix_data_o, pix_x_o, pix_y_o, sof_o, eol_o);
endinterface

// File: rtl/cmos_sync_edge.sv
// cmos_sync_edge: registers the DVP bus once and derives vs/de edge strobes from the registered copies
module cmos_sync_edge (
   input  logic       pclk,
   input  logic       rst_n,
   input  logic       vs_i,
   input  logic       de_i,
   input  logic [7:0] pdata_i,
   output logic       de_r,
   output logic [7:0] pd_r,
   output logic       vs_rise,
   output logic       de_rise,
   output logic       de_fall
);
   logic vs_r, vs_d, de_d;
   always_ff @(posedge pclk or negedge rst_n)
      if (!rst_n) {vs_r, vs_d, de_r, de_d, pd_r} <= '0;
      else {vs_r, vs_d, de_r, de_d, pd_r} <= {vs_i, vs_r, de_i, de_r, pdata_i};
   assign vs_rise = vs_r & ~vs_d;
   assign de_rise = de_r & ~de_d;
   assign de_fall = ~de_r & de_d;
endmodule

// File: rtl/cmos_pixel_packer.sv
// cmos_pixel_packer: packs DVP bytes into BPP-byte pixels with coordinates, crop window and short-line detection
module cmos_pixel_packer import cmos_pkg::*; #(
   parameter int BPP     = BPP_RGB565,
   parameter int SWAP    = 0,
   parameter int COORD_W = 12,
   parameter int FCNT_W  = 8
) (
   input  logic                pclk,
   input  logic                rst_n,
   input  logic                vs_i,
   input  logic                de_i,
   input  logic [7:0]          pdata_i,
   input  logic [COORD_W-1:0]  crop_x0_i,
   input  logic [COORD_W-1:0]  crop_y0_i,
   input  logic [COORD_W-1:0]  crop_w_i,
   input  logic [COORD_W-1:0]  crop_h_i,
   output logic [FCNT_W-1:0]   frame_cnt_o,
   output logic                err_short_o,
   cmos_pixel_packer_if.master pix
);
   if (BPP < BPP_MIN || BPP > BPP_MAX) begin : g_bpp_chk
      $error("cmos_pixel_packer: BPP out of range");
   end
   localparam logic [COORD_W-1:0] COORD_MAX = '1;
   localparam logic [1:0]         LAST      = 2'(BPP - 1);
   state_t             state_q, state_d;
   logic               de_r, de_rise, de_fall, vs_rise;
   logic [7:0]         pd_r;
   logic [1:0]         idx_q, idx_eff;
   logic [COORD_W-1:0] col_q, row_q, dcol_q, drow_q, x0_q, y0_q, w_q, h_q;
   logic [COORD_W:0]   x_end, y_end;
   logic [8*BPP-1:0]   asm_q;
   logic               gather, complete, line_end, line_pix_q, done_q, sof_arm_q, keep, eol;

   cmos_sync_edge u_sync (
      .pclk(pclk), .rst_n(rst_n), .vs_i(vs_i), .de_i(de_i), .pdata_i(pdata_i),
      .de_r(de_r), .pd_r(pd_r), .vs_rise(vs_rise), .de_rise(de_rise), .de_fall(de_fall)
   );

   // the first byte of a line arrives with de_rise, while the FSM still reads S_HBLANK
   assign gather   = !vs_rise && de_r && (state_q == S_ACTIVE || (state_q == S_HBLANK && de_rise));
   assign idx_eff  = de_rise ? 2'd0 : idx_q;
   assign complete = gather && idx_eff == LAST;
   assign line_end = !vs_rise && state_q == S_ACTIVE && de_fall;

   always_comb
      state_d = vs_rise                              ? S_HBLANK :
                (state_q == S_HBLANK && de_rise)     ? S_ACTIVE :
                (state_q == S_ACTIVE && de_fall)     ? S_HBLANK : state_q;

   always_ff @(posedge pclk or negedge rst_n)
      if (!rst_n) state_q <= S_WAIT_FRAME;
      else state_q <= state_d;

   always_ff @(posedge pclk or negedge rst_n)
      if (!rst_n) begin
         {idx_q, col_q, row_q, dcol_q, drow_q, x0_q, y0_q, w_q, h_q} <= '0;
         {asm_q, line_pix_q, done_q, sof_arm_q, err_short_o, frame_cnt_o} <= '0;
      end else begin
         done_q      <= complete;
         err_short_o <= line_end && idx_q != 2'd0;
         for (int i = 0; i < BPP; i++)
            if (gather && idx_eff == 2'(i)) asm_q[(SWAP != 0 ? 8*i : 8*(BPP-1-i)) +: 8] <= pd_r;
         if (complete) begin
            dcol_q <= col_q;
            drow_q <= row_q;
         end
         if (vs_rise) begin
            {x0_q, y0_q, w_q, h_q} <= {crop_x0_i, crop_y0_i, crop_w_i, crop_h_i};
            {idx_q, col_q, row_q, line_pix_q} <= '0;
            sof_arm_q <= 1'b1;
            if (state_q != S_WAIT_FRAME) frame_cnt_o <= frame_cnt_o + 1'b1;
         end else begin
            if (done_q && keep) sof_arm_q <= 1'b0;
            if (gather) begin
               idx_q <= complete ? 2'd0 : idx_eff + 2'd1;
               if (complete) begin
                  line_pix_q <= 1'b1;
                  if (col_q != COORD_MAX) col_q <= col_q + 1'b1;
               end
            end else if (line_end) begin
               {idx_q, col_q, line_pix_q} <= '0;
               if (line_pix_q && row_q != COORD_MAX) row_q <= row_q + 1'b1;
            end
         end
      end

   // window ends carry one extra bit so x0+w never wraps
   assign x_end = {1'b0, x0_q} + {1'b0, w_q};
   assign y_end = {1'b0, y0_q} + {1'b0, h_q};
   assign keep  = dcol_q >= x0_q && (w_q == '0 || {1'b0, dcol_q} < x_end) &&
                  drow_q >= y0_q && (h_q == '0 || {1'b0, drow_q} < y_end);
   assign eol   = w_q != '0 && {1'b0, dcol_q} == x_end - 1'b1;

   always_ff @(posedge pclk or negedge rst_n)
      if (!rst_n) begin
         pix.pix_vld_o  <= 1'b0;
         pix.pix_data_o <= '0;
         pix.pix_x_o    <= '0;
         pix.pix_y_o    <= '0;
         pix.sof_o      <= 1'b0;
         pix.eol_o      <= 1'b0;
      end else begin
         pix.pix_vld_o <= done_q && keep;
         if (done_q && keep) begin
            pix.pix_data_o <= asm_q;
            pix.pix_x_o    <= dcol_q - x0_q;
            pix.pix_y_o    <= drow_q - y0_q;
            pix.sof_o      <= sof_arm_q;
            pix.eol_o      <= eol;
         end
      end
endmodule

// File: tb/tb_cmos_pixel_packer.sv
// tb_cmos_pixel_packer: directed checks of a BPP=2/SWAP=0 and a BPP=3/SWAP=1 packer sharing one DVP bus
module tb_cmos_pixel_packer;
   localparam int CW = 12;
   logic          pclk = 1'b0, rst_n = 1'b0, vs_i = 1'b0, de_i = 1'b0;
   logic [7:0]    pdata_i = '0;
   logic [CW-1:0] crop_x0 = '0, crop_y0 = '0, crop_w = '0, crop_h = '0;
   logic [7:0]    fcnt2, fcnt3;
   logic          err2, err3;
   int            n_cmp = 0, n_bad = 0, err_cnt = 0, fc_exp = 0;
   bit            fresh = 1'b1;
   typedef struct packed {logic [15:0] d; logic [CW-1:0] x; logic [CW-1:0] y; logic sof; logic eol;} pix_t;
   pix_t          q[$];

   cmos_pixel_packer_if #(.BPP(2), .COORD_W(CW)) pix2 ();
   cmos_pixel_packer_if #(.BPP(3), .COORD_W(CW)) pix3 ();

   cmos_pixel_packer #(.BPP(2), .SWAP(0), .COORD_W(CW), .FCNT_W(8)) dut2 (
      .pclk(pclk), .rst_n(rst_n), .vs_i(vs_i), .de_i(de_i), .pdata_i(pdata_i),
      .crop_x0_i(crop_x0), .crop_y0_i(crop_y0), .crop_w_i(crop_w), .crop_h_i(crop_h),
      .frame_cnt_o(fcnt2), .err_short_o(err2), .pix(pix2)
   );
   cmos_pixel_packer #(.BPP(3), .SWAP(1), .COORD_W(CW), .FCNT_W(8)) dut3 (
      .pclk(pclk), .rst_n(rst_n), .vs_i(vs_i), .de_i(de_i), .pdata_i(pdata_i),
      .crop_x0_i(crop_x0), .crop_y0_i(crop_y0), .crop_w_i(crop_w), .crop_h_i(crop_h),
      .frame_cnt_o(fcnt3), .err_short_o(err3), .pix(pix3)
   );

   always #5 pclk = ~pclk;

   always @(negedge pclk) begin
      if (pix2.pix_vld_o) q.push_back('{d: pix2.pix_data_o, x: pix2.pix_x_o, y: pix2.pix_y_o, sof: pix2.sof_o, eol: pix2.eol_o});
      if (err2) err_cnt++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic pix_t mk(input logic [15:0] dv, input int xv, input int yv, input logic sv, input logic ev);
      mk = '{d: dv, x: CW'(xv), y: CW'(yv), sof: sv, eol: ev};
   endfunction

   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   task automatic drive(input logic v, input logic d, input logic [7:0] b);
      vs_i = v; de_i = d; pdata_i = b;
      tick();
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 1'b0, 8'h00);
   endtask

   task automatic start_frame();
      drive(1'b1, 1'b0, 8'h00);
      drive(1'b1, 1'b0, 8'h00);
      idle(3);
      if (!fresh) fc_exp++;
      fresh = 1'b0;
   endtask

   task automatic line(input int n, input logic [7:0] b0);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b1, b0 + 8'(i));
      idle(4);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) tick();
      n_cmp++;
      if (pix2.pix_vld_o !== 1'b0 || pix2.pix_data_o !== '0 || pix2.pix_x_o !== '0 || pix2.pix_y_o !== '0 || pix2.sof_o !== 1'b0 || pix2.eol_o !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_pix2: vld=%b data=%h x=%0d y=%0d sof=%b eol=%b, required all 0", pix2.pix_vld_o, pix2.pix_data_o, pix2.pix_x_o, pix2.pix_y_o, pix2.sof_o, pix2.eol_o);
      end
      n_cmp++;
      if (fcnt2 !== 8'd0 || err2 !== 1'b0 || fcnt3 !== 8'd0 || err3 !== 1'b0 || pix3.pix_vld_o !== 1'b0 || pix3.pix_data_o !== '0) begin
         n_bad++;
         $display("FAIL reset_misc: fcnt2=%0d err2=%b fcnt3=%0d err3=%b vld3=%b data3=%h, required all 0", fcnt2, err2, fcnt3, err3, pix3.pix_vld_o, pix3.pix_data_o);
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      logic [7:0] b;
      pix_t e;
      q.delete();
      start_frame();
      line(8, 8'h01);
      line(8, 8'h09);
      n_cmp++;
      if (q.size() != 8) begin
         n_bad++;
         $display("FAIL basic_count: got %0d strobes, required 8", q.size());
      end
      for (int i = 0; i < 8 && i < q.size(); i++) begin
         b = 8'(2*i + 1);
         e = mk({b, b + 8'd1}, i % 4, i / 4, i == 0, 1'b0);
         n_cmp++;
         if (q[i] !== e) begin
            n_bad++;
            $display("FAIL basic_pix%0d: got d=%h x=%0d y=%0d sof=%b eol=%b, required d=%h x=%0d y=%0d sof=%b eol=%b", i, q[i].d, q[i].x, q[i].y, q[i].sof, q[i].eol, e.d, e.x, e.y, e.sof, e.eol);
         end
      end
      n_cmp++;
      if (fcnt2 !== 8'(fc_exp) || fc_exp != 0) begin
         n_bad++;
         $display("FAIL basic_fcnt_first: got %0d, required 0", fcnt2);
      end
      start_frame();
      n_cmp++;
      if (fcnt2 !== 8'd1 || fcnt3 !== 8'd1) begin
         n_bad++;
         $display("FAIL basic_fcnt_second: got %0d/%0d, required 1/1", fcnt2, fcnt3);
      end
   endtask

   task automatic test_bpp3();
      drive(1'b0, 1'b1, 8'hAA);
      drive(1'b0, 1'b1, 8'hBB);
      drive(1'b0, 1'b1, 8'hCC);
      n_cmp++;
      if (pix3.pix_vld_o !== 1'b0) begin
         n_bad++;
         $display("FAIL bpp3_lat0: vld=%b, required 0", pix3.pix_vld_o);
      end
      drive(1'b0, 1'b1, 8'h11);
      n_cmp++;
      if (pix3.pix_vld_o !== 1'b0) begin
         n_bad++;
         $display("FAIL bpp3_lat1: vld=%b, required 0", pix3.pix_vld_o);
      end
      drive(1'b0, 1'b1, 8'h22);
      n_cmp++;
      if (pix3.pix_vld_o !== 1'b1 || pix3.pix_data_o !== 24'hCCBBAA || pix3.pix_x_o !== 12'd0 || pix3.pix_y_o !== 12'd0 || pix3.sof_o !== 1'b1) begin
         n_bad++;
         $display("FAIL bpp3_pix0: vld=%b data=%h x=%0d y=%0d sof=%b, required 1 ccbbaa 0 0 1", pix3.pix_vld_o, pix3.pix_data_o, pix3.pix_x_o, pix3.pix_y_o, pix3.sof_o);
      end
      drive(1'b0, 1'b1, 8'h33);
      n_cmp++;
      if (pix3.pix_vld_o !== 1'b0) begin
         n_bad++;
         $display("FAIL bpp3_strobe_len: vld=%b, required 0", pix3.pix_vld_o);
      end
      idle(1);
      n_cmp++;
      if (pix3.pix_vld_o !== 1'b0 || pix3.pix_data_o !== 24'hCCBBAA) begin
         n_bad++;
         $display("FAIL bpp3_hold: vld=%b data=%h, required 0 ccbbaa", pix3.pix_vld_o, pix3.pix_data_o);
      end
      idle(1);
      n_cmp++;
      if (pix3.pix_vld_o !== 1'b1 || pix3.pix_data_o !== 24'h332211 || pix3.pix_x_o !== 12'd1 || pix3.sof_o !== 1'b0) begin
         n_bad++;
         $display("FAIL bpp3_pix1: vld=%b data=%h x=%0d sof=%b, required 1 332211 1 0", pix3.pix_vld_o, pix3.pix_data_o, pix3.pix_x_o, pix3.sof_o);
      end
      idle(3);
   endtask

   task automatic test_crop();
      pix_t exp[$];
      q.delete();
      {crop_x0, crop_w, crop_y0, crop_h} = {12'd1, 12'd2, 12'd1, 12'd1};
      start_frame();
      line(8, 8'h00);
      {crop_x0, crop_w, crop_y0, crop_h} = '0;
      line(8, 8'h10);
      line(8, 8'h20);
      exp = '{mk(16'h1213, 0, 0, 1'b1, 1'b0), mk(16'h1415, 1, 0, 1'b0, 1'b1)};
      n_cmp++;
      if (q.size() != 2) begin
         n_bad++;
         $display("FAIL crop_count: got %0d strobes, required 2", q.size());
      end
      for (int i = 0; i < 2 && i < q.size(); i++) begin
         n_cmp++;
         if (q[i] !== exp[i]) begin
            n_bad++;
            $display("FAIL crop_pix%0d: got d=%h x=%0d y=%0d sof=%b eol=%b, required d=%h x=%0d y=%0d sof=%b eol=%b", i, q[i].d, q[i].x, q[i].y, q[i].sof, q[i].eol, exp[i].d, exp[i].x, exp[i].y, exp[i].sof, exp[i].eol);
         end
      end
      q.delete();
      start_frame();
      line(8, 8'h30);
      n_cmp++;
      if (q.size() != 4 || q[0] !== mk(16'h3031, 0, 0, 1'b1, 1'b0) || q[3] !== mk(16'h3637, 3, 0, 1'b0, 1'b0)) begin
         n_bad++;
         $display("FAIL crop_released: got %0d strobes first d=%h, required 4 strobes 3031..3637 without eol", q.size(), q.size() > 0 ? q[0].d : 16'h0);
      end
   endtask

   task automatic test_short_line();
      pix_t exp[$];
      int base;
      q.delete();
      base = err_cnt;
      start_frame();
      line(7, 8'h21);
      line(4, 8'h31);
      exp = '{mk(16'h2122, 0, 0, 1'b1, 1'b0), mk(16'h2324, 1, 0, 1'b0, 1'b0), mk(16'h2526, 2, 0, 1'b0, 1'b0),
              mk(16'h3132, 0, 1, 1'b0, 1'b0), mk(16'h3334, 1, 1, 1'b0, 1'b0)};
      n_cmp++;
      if (q.size() != 5) begin
         n_bad++;
         $display("FAIL short_count: got %0d strobes, required 5", q.size());
      end
      for (int i = 0; i < 5 && i < q.size(); i++) begin
         n_cmp++;
         if (q[i] !== exp[i]) begin
            n_bad++;
            $display("FAIL short_pix%0d: got d=%h x=%0d y=%0d sof=%b, required d=%h x=%0d y=%0d sof=%b", i, q[i].d, q[i].x, q[i].y, q[i].sof, exp[i].d, exp[i].x, exp[i].y, exp[i].sof);
         end
      end
      n_cmp++;
      if (err_cnt - base != 1) begin
         n_bad++;
         $display("FAIL short_err: got %0d error pulses, required 1", err_cnt - base);
      end
   endtask

   task automatic test_vs_during_de();
      pix_t exp[$];
      int base;
      q.delete();
      base = err_cnt;
      start_frame();
      drive(1'b0, 1'b1, 8'h41);
      drive(1'b0, 1'b1, 8'h42);
      drive(1'b0, 1'b1, 8'h43);
      drive(1'b1, 1'b1, 8'h44);
      drive(1'b1, 1'b1, 8'h45);
      drive(1'b0, 1'b1, 8'h46);
      idle(4);
      fc_exp++;
      line(4, 8'h51);
      exp = '{mk(16'h4142, 0, 0, 1'b1, 1'b0), mk(16'h5152, 0, 0, 1'b1, 1'b0), mk(16'h5354, 1, 0, 1'b0, 1'b0)};
      n_cmp++;
      if (q.size() != 3) begin
         n_bad++;
         $display("FAIL vsde_count: got %0d strobes, required 3", q.size());
      end
      for (int i = 0; i < 3 && i < q.size(); i++) begin
         n_cmp++;
         if (q[i] !== exp[i]) begin
            n_bad++;
            $display("FAIL vsde_pix%0d: got d=%h x=%0d y=%0d sof=%b, required d=%h x=%0d y=%0d sof=%b", i, q[i].d, q[i].x, q[i].y, q[i].sof, exp[i].d, exp[i].x, exp[i].y, exp[i].sof);
         end
      end
      n_cmp++;
      if (err_cnt != base || fcnt2 !== 8'(fc_exp)) begin
         n_bad++;
         $display("FAIL vsde_err_fcnt: got err=%0d fcnt=%0d, required err=0 fcnt=%0d", err_cnt - base, fcnt2, fc_exp);
      end
   endtask

   task automatic test_reset_midline();
      start_frame();
      drive(1'b0, 1'b1, 8'h61);
      drive(1'b0, 1'b1, 8'h62);
      drive(1'b0, 1'b1, 8'h63);
      q.delete();
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (pix2.pix_vld_o !== 1'b0 || pix2.pix_data_o !== '0 || pix2.pix_x_o !== '0 || pix2.pix_y_o !== '0 || fcnt2 !== 8'd0 || err2 !== 1'b0) begin
         n_bad++;
         $display("FAIL rst_mid_outputs: vld=%b data=%h x=%0d y=%0d fcnt=%0d err=%b, required all 0", pix2.pix_vld_o, pix2.pix_data_o, pix2.pix_x_o, pix2.pix_y_o, fcnt2, err2);
      end
      tick();
      rst_n = 1'b1;
      drive(1'b0, 1'b1, 8'h64);
      drive(1'b0, 1'b1, 8'h65);
      idle(4);
      line(4, 8'h68);
      n_cmp++;
      if (q.size() != 0) begin
         n_bad++;
         $display("FAIL rst_mid_ignored: got %0d strobes before vs, required 0", q.size());
      end
      fresh = 1'b1;
      fc_exp = 0;
      start_frame();
      line(4, 8'h71);
      n_cmp++;
      if (q.size() != 2 || q[0] !== mk(16'h7172, 0, 0, 1'b1, 1'b0) || q[1] !== mk(16'h7374, 1, 0, 1'b0, 1'b0) || fcnt2 !== 8'd0) begin
         n_bad++;
         $display("FAIL rst_mid_resume: got %0d strobes first d=%h fcnt=%0d, required 2 strobes 7172,7374 fcnt 0", q.size(), q.size() > 0 ? q[0].d : 16'h0, fcnt2);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_bpp3();
      test_crop();
      test_short_line();
      test_vs_during_de();
      test_reset_midline();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
